// File: rtl/alu_serial_driver.sv
// alu_serial_driver: drives one combinational 1-bit ALU slice through all WIDTH
// bit positions, LSB first. Requests arrive on a valid/ready handshake. The
// assembled word and its flags are returned on a second valid/ready handshake.
//
// state | meaning
// IDLE  | ready for a request; slice drive outputs held at 0
// PASS1 | one bit per cycle: the requested op (slt runs its subtract here)
// PASS2 | slt only: second sweep, Less fed with the sign captured in PASS1
// DONE  | response held until resp_ready
module alu_serial_driver #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_carry,
    output logic             resp_overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_binvert,
    output logic             slice_carryin,
    output logic [2:0]       slice_operation,
    output logic             slice_less,
    input  logic             slice_result,
    input  logic             slice_carryout,
    input  logic             slice_set,
    input  logic             slice_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [2:0]       OP_SUB   = 3'b110;
    localparam logic [2:0]       OP_SLT   = 3'b111;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [CNT_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_set;
    logic [WIDTH-1:0]   r_result;
    logic               r_resp_carry;
    logic               r_resp_overflow;

    logic               w_accept;
    logic               w_last;
    logic               w_binv;

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_last   = (r_idx == LAST_IDX);
    // sub and slt both subtract, so B is inverted and the carry chain seeded with 1
    assign w_binv   = (r_op[2:1] == 2'b11);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_PASS1;
            S_PASS1: if (w_last) w_state_nxt = (r_op == OP_SLT) ? S_PASS2 : S_DONE;
            S_PASS2: if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (resp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch, bit index, carry chain and result assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a             <= '0;
            r_b             <= '0;
            r_op            <= '0;
            r_idx           <= '0;
            r_carry         <= 1'b0;
            r_set           <= 1'b0;
            r_result        <= '0;
            r_resp_carry    <= 1'b0;
            r_resp_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_op    <= req_op;
                        r_idx   <= '0;
                        r_carry <= (req_op[2:1] == 2'b11);
                    end
                end
                S_PASS1: begin
                    r_result[r_idx] <= slice_result;
                    if (w_last) begin
                        r_resp_carry    <= slice_carryout;
                        r_resp_overflow <= slice_overflow;
                        r_set           <= slice_set;
                        r_idx           <= '0;
                        // PASS2 restarts the subtract chain; ignored when going to DONE
                        r_carry         <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_carry <= slice_carryout;
                    end
                end
                S_PASS2: begin
                    r_result[r_idx] <= slice_result;
                    r_carry         <= slice_carryout;
                    r_idx           <= w_last ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Slice drive and handshake outputs; everything not in use is held at 0
    always_comb begin
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_result     = '0;
        resp_zero       = 1'b0;
        resp_carry      = 1'b0;
        resp_overflow   = 1'b0;
        slice_a         = 1'b0;
        slice_b         = 1'b0;
        slice_binvert   = 1'b0;
        slice_carryin   = 1'b0;
        slice_operation = 3'b000;
        slice_less      = 1'b0;
        case (r_state)
            S_IDLE: req_ready = 1'b1;
            S_PASS1: begin
                slice_a         = r_a[r_idx];
                slice_b         = r_b[r_idx];
                slice_binvert   = w_binv;
                slice_carryin   = r_carry;
                slice_operation = (r_op == OP_SLT) ? OP_SUB : r_op;
            end
            S_PASS2: begin
                slice_a         = r_a[r_idx];
                slice_b         = r_b[r_idx];
                slice_binvert   = 1'b1;
                slice_carryin   = r_carry;
                slice_operation = OP_SLT;
                slice_less      = (r_idx == '0) ? r_set : 1'b0;
            end
            S_DONE: begin
                resp_valid    = 1'b1;
                resp_result   = r_result;
                resp_zero     = (r_result == '0);
                resp_carry    = r_resp_carry;
                resp_overflow = r_resp_overflow;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_serial_driver.sv
// tb_alu_serial_driver: directed bench for alu_serial_driver with a behavioural
// 1-bit ALU slice attached to the slice port.
module tb_alu_serial_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_result;
    logic         resp_zero;
    logic         resp_carry;
    logic         resp_overflow;
    logic         slice_a;
    logic         slice_b;
    logic         slice_binvert;
    logic         slice_carryin;
    logic [2:0]   slice_operation;
    logic         slice_less;
    logic         slice_result;
    logic         slice_carryout;
    logic         slice_set;
    logic         slice_overflow;

    int checks   = 0;
    int failures = 0;

    alu_serial_driver #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_zero(resp_zero), .resp_carry(resp_carry), .resp_overflow(resp_overflow),
        .slice_a(slice_a), .slice_b(slice_b), .slice_binvert(slice_binvert),
        .slice_carryin(slice_carryin), .slice_operation(slice_operation),
        .slice_less(slice_less), .slice_result(slice_result),
        .slice_carryout(slice_carryout), .slice_set(slice_set),
        .slice_overflow(slice_overflow)
    );

    always #5 clk = ~clk;

    // Behavioural slice: and/or/add/nand/nor/add/sub/less; overflow only for arithmetic ops
    logic s_bb, s_sum;
    always_comb begin
        s_bb           = slice_b ^ slice_binvert;
        s_sum          = slice_a ^ s_bb ^ slice_carryin;
        slice_carryout = (slice_a & s_bb) | (slice_a & slice_carryin) | (s_bb & slice_carryin);
        slice_set      = s_sum;
        case (slice_operation)
            3'b000:  slice_result = slice_a & s_bb;
            3'b001:  slice_result = slice_a | s_bb;
            3'b011:  slice_result = ~(slice_a & s_bb);
            3'b100:  slice_result = ~(slice_a | s_bb);
            3'b111:  slice_result = slice_less;
            default: slice_result = s_sum;
        endcase
        slice_overflow = (slice_operation == 3'b010 || slice_operation[2:1] == 2'b11)
                         ? (slice_carryin ^ slice_carryout) : 1'b0;
    end

    // Issue one request and wait (bounded) for resp_valid; resp_ready stays low
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic car, output logic ov,
                          output logic zr, output int lat, output int less_cnt,
                          output int less_pos, output logic binv0, output logic cin0,
                          output logic [2:0] op0, output logic [2:0] op8);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'b001; req_a = ~a; req_b = ~b;
        binv0 = slice_binvert; cin0 = slice_carryin; op0 = slice_operation; op8 = 3'b000;
        lat = 0; less_cnt = 0; less_pos = -1;
        while (!resp_valid && lat < 40) begin
            if (slice_less) begin less_cnt++; less_pos = lat; end
            if (lat == W) op8 = slice_operation;
            @(posedge clk); #1;
            lat++;
        end
        res = resp_result; car = resp_carry; ov = resp_overflow; zr = resp_zero;
    endtask

    task automatic release_resp();
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    logic [W-1:0] t_res;
    logic t_car, t_ov, t_zr, t_binv0, t_cin0;
    logic [2:0] t_op0, t_op8;
    int t_lat, t_lcnt, t_lpos;

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++;
        if ({resp_valid, resp_result, resp_zero, resp_carry, resp_overflow} !== '0) begin
            failures++; $display("FAIL reset_resp got=%b exp=0", {resp_valid, resp_result, resp_zero, resp_carry, resp_overflow});
        end
        checks++;
        if ({slice_a, slice_b, slice_binvert, slice_carryin, slice_operation, slice_less} !== '0) begin
            failures++; $display("FAIL reset_slice got=%b exp=0", {slice_a, slice_b, slice_binvert, slice_carryin, slice_operation, slice_less});
        end
    endtask

    task automatic test_add();
        run_op(3'b010, 8'h7F, 8'h01, t_res, t_car, t_ov, t_zr, t_lat, t_lcnt, t_lpos, t_binv0, t_cin0, t_op0, t_op8);
        checks++;
        if (t_lat !== W) begin failures++; $display("FAIL add_latency got=%0d exp=%0d", t_lat, W); end
        checks++;
        if ({t_res, t_ov, t_car, t_zr} !== {8'h80, 1'b1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL add_7f_01 got res=%h ov=%b c=%b z=%b exp res=80 ov=1 c=0 z=0", t_res, t_ov, t_car, t_zr);
        end
        checks++;
        if ({t_binv0, t_cin0} !== 2'b00) begin failures++; $display("FAIL add_bit0_binv_cin got=%b exp=00", {t_binv0, t_cin0}); end
        release_resp();
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL add_return_idle got=%b exp=01", {resp_valid, req_ready}); end
    endtask

    task automatic test_sub();
        run_op(3'b110, 8'h05, 8'h05, t_res, t_car, t_ov, t_zr, t_lat, t_lcnt, t_lpos, t_binv0, t_cin0, t_op0, t_op8);
        checks++;
        if ({t_res, t_zr, t_car, t_ov} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
            failures++; $display("FAIL sub_05_05 got res=%h z=%b c=%b ov=%b exp res=00 z=1 c=1 ov=0", t_res, t_zr, t_car, t_ov);
        end
        checks++;
        if ({t_binv0, t_cin0} !== 2'b11) begin failures++; $display("FAIL sub_bit0_binv_cin got=%b exp=11", {t_binv0, t_cin0}); end
        release_resp();
    endtask

    task automatic test_slt();
        run_op(3'b111, 8'hFE, 8'h03, t_res, t_car, t_ov, t_zr, t_lat, t_lcnt, t_lpos, t_binv0, t_cin0, t_op0, t_op8);
        checks++;
        if (t_res !== 8'h01) begin failures++; $display("FAIL slt_fe_03 got=%h exp=01", t_res); end
        checks++;
        if (t_lat !== 2 * W) begin failures++; $display("FAIL slt_latency got=%0d exp=%0d", t_lat, 2 * W); end
        checks++;
        if (t_lcnt !== 1 || t_lpos !== W) begin
            failures++; $display("FAIL slt_less_pulse got cnt=%0d pos=%0d exp cnt=1 pos=%0d", t_lcnt, t_lpos, W);
        end
        checks++;
        if ({t_op0, t_op8, t_binv0, t_cin0} !== {3'b110, 3'b111, 1'b1, 1'b1}) begin
            failures++; $display("FAIL slt_slice_ops got p1=%b p2=%b binv=%b cin=%b exp p1=110 p2=111 binv=1 cin=1", t_op0, t_op8, t_binv0, t_cin0);
        end
        release_resp();
        run_op(3'b111, 8'h03, 8'hFE, t_res, t_car, t_ov, t_zr, t_lat, t_lcnt, t_lpos, t_binv0, t_cin0, t_op0, t_op8);
        checks++;
        if ({t_res, t_zr, t_lcnt} !== {8'h00, 1'b1, 32'd0}) begin
            failures++; $display("FAIL slt_03_fe got res=%h z=%b less_cnt=%0d exp res=00 z=1 less_cnt=0", t_res, t_zr, t_lcnt);
        end
        release_resp();
    endtask

    task automatic test_logic();
        logic [2:0] ops [4] = '{3'b000, 3'b001, 3'b011, 3'b100};
        logic [7:0] exp [4] = '{8'hC0, 8'hFC, 8'h3F, 8'h03};
        for (int k = 0; k < 4; k++) begin
            run_op(ops[k], 8'hF0, 8'hCC, t_res, t_car, t_ov, t_zr, t_lat, t_lcnt, t_lpos, t_binv0, t_cin0, t_op0, t_op8);
            checks++;
            if ({t_res, t_ov, t_zr} !== {exp[k], 1'b0, 1'b0}) begin
                failures++; $display("FAIL logic_op_%b got res=%h ov=%b z=%b exp res=%h ov=0 z=0", ops[k], t_res, t_ov, t_zr, exp[k]);
            end
            release_resp();
        end
    endtask

    task automatic test_back_to_back();
        run_op(3'b110, 8'h10, 8'h20, t_res, t_car, t_ov, t_zr, t_lat, t_lcnt, t_lpos, t_binv0, t_cin0, t_op0, t_op8);
        checks++;
        if ({t_res, t_car, t_ov} !== {8'hF0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL b2b_sub got res=%h c=%b ov=%b exp res=f0 c=0 ov=0", t_res, t_car, t_ov);
        end
        release_resp();
        run_op(3'b010, 8'h80, 8'h80, t_res, t_car, t_ov, t_zr, t_lat, t_lcnt, t_lpos, t_binv0, t_cin0, t_op0, t_op8);
        checks++;
        if ({t_res, t_car, t_ov, t_zr} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
            failures++; $display("FAIL b2b_add_80_80 got res=%h c=%b ov=%b z=%b exp res=00 c=1 ov=1 z=1", t_res, t_car, t_ov, t_zr);
        end
        release_resp();
        run_op(3'b101, 8'h03, 8'h04, t_res, t_car, t_ov, t_zr, t_lat, t_lcnt, t_lpos, t_binv0, t_cin0, t_op0, t_op8);
        checks++;
        if ({t_res, t_ov, t_lat} !== {8'h07, 1'b0, W}) begin
            failures++; $display("FAIL op101_add got res=%h ov=%b lat=%0d exp res=07 ov=0 lat=%0d", t_res, t_ov, t_lat, W);
        end
        release_resp();
    endtask

    task automatic test_backpressure();
        int bad;
        run_op(3'b010, 8'h10, 8'h20, t_res, t_car, t_ov, t_zr, t_lat, t_lcnt, t_lpos, t_binv0, t_cin0, t_op0, t_op8);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = c[0]; req_op = 3'b000; req_a = 8'hAA; req_b = 8'h55;
            if (!resp_valid || resp_result !== 8'h30 || req_ready !== 1'b0 || resp_zero !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL backpressure_hold got bad_cycles=%0d exp=0", bad); end
        release_resp();
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL backpressure_release got=%b exp=01", {resp_valid, req_ready}); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin failures++; $display("FAIL backpressure_no_extra got resp_valid=%b exp=0", resp_valid); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'b010; req_a = 8'h0F; req_b = 8'h01;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({slice_a, slice_b, slice_operation} !== {1'b1, 1'b0, 3'b010}) begin
            failures++; $display("FAIL mid_bit3_drive got=%b exp=10010", {slice_a, slice_b, slice_operation});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({resp_valid, resp_result, slice_a, slice_b, slice_binvert, slice_carryin, slice_operation, slice_less, req_ready} !== {17'd0, 1'b1}) begin
            failures++; $display("FAIL mid_reset_outputs got=%b exp=%b", {resp_valid, resp_result, slice_a, slice_b, slice_binvert, slice_carryin, slice_operation, slice_less, req_ready}, {17'd0, 1'b1});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (resp_valid) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL mid_reset_no_resp got valid_cycles=%0d exp=0", seen); end
        run_op(3'b010, 8'h01, 8'h02, t_res, t_car, t_ov, t_zr, t_lat, t_lcnt, t_lpos, t_binv0, t_cin0, t_op0, t_op8);
        checks++;
        if ({t_res, t_lat} !== {8'h03, W}) begin failures++; $display("FAIL mid_reset_next_add got res=%h lat=%0d exp res=03 lat=%0d", t_res, t_lat, W); end
        release_resp();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        #23;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
